// File: rtl/noc_packet_injector.sv
// noc_packet_injector: source-side network interface for the XY-routed NoC.
// Stamps this node's coordinates onto PE requests and buffers them in a small FIFO.
// It then injects them into the local router over a 4-phase req/ack link.
// Packet layout: [34:33] src_x, [32:31] src_y, [30:29] dst_x, [28:27] dst_y, [26:0] payload.

module noc_packet_injector #(
  parameter int WIDTH = 35,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pe_valid,
  output logic             pe_ready,
  input  logic [1:0]       pe_dst_x,
  input  logic [1:0]       pe_dst_y,
  input  logic [WIDTH-9:0] pe_payload,
  output logic             link_req,
  input  logic             link_ack,
  output logic [WIDTH-1:0] link_data,
  output logic [15:0]      pkt_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [1:0] SRC_X = 2'(MY_X);
  localparam logic [1:0] SRC_Y = 2'(MY_Y);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             ack_meta;
  logic             ack_s;
  logic [1:0]       state;
  logic [15:0]      pkt_cnt_q;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             hs_done;

  // pe_ready comes purely from registered occupancy, so a pop on the same edge cannot open it early.
  assign fifo_empty = (occ == '0);
  assign pe_ready   = (occ != FULL_OCC);
  assign push       = pe_valid & pe_ready;
  assign hs_done    = (state == ST_RELEASE) & ~ack_s;
  assign pop        = ~fifo_empty & ((state == ST_IDLE) | hs_done);
  assign busy       = (state != ST_IDLE) | ~fifo_empty;
  assign pkt_count  = pkt_cnt_q;

  // Two-flop synchronizer for the acknowledge coming from the asynchronous router fabric
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= link_ack;
      ack_s    <= ack_meta;
    end
  end

  // FIFO storage: the tail is written with the source coordinates stamped in front
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {SRC_X, SRC_Y, pe_dst_x, pe_dst_y, pe_payload};
    end
  end

  // FIFO pointers wrap naturally at DEPTH; occupancy holds when push and pop coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        occ <= occ + (AW+1)'(1);
      end else if (!push && pop) begin
        occ <= occ - (AW+1)'(1);
      end
    end
  end

  // Handshake FSM: link_data is loaded only on a pop and stays frozen through REQ and RELEASE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      link_req  <= 1'b0;
      link_data <= '0;
      pkt_cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            link_data <= fifo_mem[rd_ptr];
            link_req  <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            link_req <= 1'b0;
            state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (hs_done) begin
            if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (pop) begin
              link_data <= fifo_mem[rd_ptr];
              link_req  <= 1'b1;
              state     <= ST_REQ;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          link_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
